tile_fill_ctrl: RTL and testbench
=================================

TILE_FILL_CTRL -- requirements
Module: tile_fill_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (system clock); resetn input 1 (reset, synchronous, active-low).
REQ-002 SHALL have CPU ports: cpu_valid input 1; cpu_wstrb input 4; cpu_addr input 32; cpu_wdata input 32; cpu_ready output 1; cpu_rdata output 32.
REQ-003 SHALL have video write-bus ports to the video peripheral: vid_valid output 1; vid_wstrb output 4; vid_addr output 32; vid_wdata output 32.
REQ-004 SHALL have port vga_vsync input 1 (active-low vsync from video timing); it is used only when TILE_FILL_VBLANK_EN is defined.
REQ-005 SHALL have parameters: TILE_BASE, default 32'h0520_0000, tile memory byte base; REG_SEL, default 4'h4, cpu_addr[23:20] value selecting engine registers.

Function
REQ-006 SHALL decode engine registers when cpu_valid and cpu_addr[23:20]==REG_SEL, word offset cpu_addr[3:2], as follows.
- Offset 0, RECT: [5:0] x0, [13:8] y0, [22:16] w (0..64), [30:24] h (0..64).
- Offset 1, TILE: [5:0] fill value.
- Offset 2, CTRL write: bit0 start, bit1 abort, bit2 clear_done.
- Offset 2, STATUS read: bit0 busy, bit1 done.
REQ-007 SHALL pulse cpu_ready high for exactly one cycle, the cycle after cpu_valid is first sampled high; cpu_ready SHALL be low the following cycle; register writes SHALL take effect on the cpu_ready cycle.
REQ-008 SHALL drive cpu_rdata with the addressed register (STATUS, RECT or TILE) during the cpu_ready cycle, and with 0 otherwise.
REQ-009 SHALL forward the CPU bus unmodified on vid_* combinationally whenever cpu_valid is high and the address is not an engine register; this is CPU priority.
REQ-010 SHALL use a FSM with states IDLE, WAIT_VS and RUN.
- IDLE to RUN on an accepted start write with w!=0 and h!=0.
- IDLE stays IDLE and done is set on a start write with w==0 or h==0.
REQ-011 In RUN, the engine SHALL issue one write per cycle in which cpu_valid is low, and SHALL stall in cycles in which cpu_valid is high.
- vid_valid=1, vid_wstrb=4'b0001, vid_wdata={26'b0,value}.
- vid_addr = TILE_BASE + ({cy[5:0],cx[5:0]} << 2).
REQ-012 SHALL iterate raster order: cx from x0 for w columns, then cy increments; x and y coordinates SHALL wrap modulo 64, giving 6-bit truncation.
REQ-013 SHALL return from RUN to IDLE after exactly w*h writes, setting done the cycle after the last write; busy SHALL be high in WAIT_VS and RUN.
REQ-014 With no CPU contention, RUN SHALL last exactly w*h cycles, and the first write SHALL occur the cycle after the start cpu_ready cycle.
REQ-015 SHALL ignore start, RECT writes and TILE writes while busy; their cpu_ready handshake SHALL still complete.
REQ-016 Abort SHALL force IDLE on the next cycle from any state, issue no further writes, and leave done unchanged.
- If abort and start are written together, abort SHALL win.
REQ-017 clear_done SHALL clear done.
- If clear_done coincides with the done-setting cycle, done SHALL be set.
REQ-018 When neither the CPU nor the engine drives vid_*, vid_valid SHALL be 0 and vid_wstrb/vid_addr/vid_wdata SHALL be 0.

Reset
REQ-019 When resetn is low at a clk edge, all of the following SHALL hold, including when reset occurs mid-fill, which aborts the fill with no further writes:
- FSM=IDLE; busy=0; done=0.
- RECT=0; TILE=0; cx/cy counters=0.
- cpu_ready=0; cpu_rdata=0; engine vid_* outputs=0.

Configuration
REQ-020 SHALL support macro TILE_FILL_VBLANK_EN.
- Defined: an accepted start SHALL enter WAIT_VS, and RUN SHALL begin the cycle after a registered falling edge of vga_vsync, with vga_vsync double-flop synchronised into clk.
- Undefined: WAIT_VS SHALL be unreachable and vga_vsync SHALL be ignored.

Structure
REQ-021 SHALL place register offsets, CTRL/STATUS bit indices, FSM state encodings and REG_SEL/TILE_BASE defaults in shared package video_pkg.
REQ-022 SHALL implement the raster coordinate generator (cx, cy, remaining count, last flag) as sub-module tile_fill_walker; the FSM, register file and bus mux SHALL remain in tile_fill_ctrl.

Verification
REQ-023 Basic fill: RECT x0=2,y0=3,w=4,h=2; TILE=5; start -> 8 writes, one per cycle, vid_addr 0x0520_0308 to 0x0520_0314 then 0x0520_0408 to 0x0520_0414, vid_wdata=5; done=1, busy=0.
REQ-024 Wrap-around: x0=62,y0=63,w=3,h=2 -> tile indices, in order, (63,62),(63,63),(63,0),(0,62),(0,63),(0,0).
REQ-025 Contention: CPU write to 0x0520_0000 issued mid-fill -> the CPU write appears on vid_* in that cycle, the engine stalls one cycle, and the total engine write count is still w*h.
REQ-026 Edge cases: w=0 start -> no writes, done=1 immediately; start while busy -> ignored; abort after 3 of 16 writes -> exactly 3 writes, busy=0, done=0.
REQ-027 Reset mid-fill: resetn low for 1 cycle after 5 writes -> no further writes, STATUS reads 0.
REQ-028 With TILE_FILL_VBLANK_EN: start while vga_vsync=1 -> busy=1 and no writes; the first write occurs 4 cycles after vga_vsync falls (2 sync flops + edge register + transition).

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the video-side blocks: engine register map,
// CTRL/STATUS bit positions, tile-fill FSM encoding and bus defaults.
package video_pkg;

  // Word offsets (cpu_addr[3:2]) of the tile-fill engine registers
  localparam logic [1:0] REG_RECT = 2'd0;
  localparam logic [1:0] REG_TILE = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  // CTRL write bits
  localparam int CTRL_START      = 0;
  localparam int CTRL_ABORT      = 1;
  localparam int CTRL_CLEAR_DONE = 2;

  // STATUS read bits (same offset as CTRL)
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  // Address decode and tile memory defaults
  localparam logic [3:0]  DEFAULT_REG_SEL   = 4'h4;
  localparam logic [31:0] DEFAULT_TILE_BASE = 32'h0520_0000;

  // Tile-fill engine states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_RUN     = 2'd2
  } fillState_t;

endpackage

// File: rtl/tile_fill_walker.sv
// Raster coordinate generator for the tile-fill engine. Loads the rectangle
// origin and size, then walks cx across w columns before bumping cy.
// Coordinates are 6 bits wide, so they wrap modulo 64 naturally.
module tile_fill_walker (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [5:0] i_x0,
  input  logic [5:0] i_y0,
  input  logic [6:0] i_w,
  input  logic [6:0] i_h,
  output logic [5:0] o_cx,
  output logic [5:0] o_cy,
  output logic       o_last
);

  logic [5:0]  r_cx;
  logic [5:0]  r_cy;
  logic [6:0]  r_colLeft;
  logic [12:0] r_remain;

  // Load the start corner and total count, then advance one tile per step;
  // x0 and w are re-read at each row end since they are frozen while busy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cx      <= '0;
      r_cy      <= '0;
      r_colLeft <= '0;
      r_remain  <= '0;
    end else if (i_load) begin
      r_cx      <= i_x0;
      r_cy      <= i_y0;
      r_colLeft <= i_w;
      r_remain  <= 13'(i_w) * 13'(i_h);
    end else if (i_step && (r_remain != 13'd0)) begin
      r_remain <= r_remain - 13'd1;
      if (r_colLeft == 7'd1) begin
        r_cx      <= i_x0;
        r_cy      <= r_cy + 6'd1;
        r_colLeft <= i_w;
      end else begin
        r_cx      <= r_cx + 6'd1;
        r_colLeft <= r_colLeft - 7'd1;
      end
    end
  end

  assign o_cx   = r_cx;
  assign o_cy   = r_cy;
  assign o_last = (r_remain == 13'd1);

endmodule

// File: rtl/tile_fill_ctrl.sv
// Tile-fill engine: CPU-visible register file, fill FSM and the shared
// video write-bus mux (CPU traffic always has priority over the engine).
// Optional feature macro TILE_FILL_VBLANK_EN: when defined, a start waits
// for a falling edge of the synchronised vga_vsync before filling.
module tile_fill_ctrl
  import video_pkg::*;
#(
  parameter logic [31:0] TILE_BASE = DEFAULT_TILE_BASE,
  parameter logic [3:0]  REG_SEL   = DEFAULT_REG_SEL
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_valid,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        vid_valid,
  output logic [3:0]  vid_wstrb,
  output logic [31:0] vid_addr,
  output logic [31:0] vid_wdata,
  input  logic        vga_vsync
);

  fillState_t  r_state;
  logic        r_done;
  logic        r_cpuReady;
  logic [31:0] r_cpuRdata;
  logic [5:0]  r_x0;
  logic [5:0]  r_y0;
  logic [6:0]  r_w;
  logic [6:0]  r_h;
  logic [5:0]  r_tile;

  logic        w_regAddr;
  logic        w_regWrite;
  logic [1:0]  w_off;
  logic        w_ctrlWrite;
  logic        w_start;
  logic        w_abort;
  logic        w_clearDone;
  logic        w_busy;
  logic        w_empty;
  logic        w_engWrite;
  logic        w_load;
  logic        w_setDone;
  logic        w_last;
  logic [5:0]  w_cx;
  logic [5:0]  w_cy;
  logic [31:0] w_readMux;

  assign w_off       = cpu_addr[3:2];
  assign w_regAddr   = (cpu_addr[23:20] == REG_SEL);
  // Writes commit at the end of the ready cycle; an all-zero strobe is a read
  assign w_regWrite  = cpu_valid && w_regAddr && r_cpuReady && (cpu_wstrb != 4'b0000);
  assign w_ctrlWrite = w_regWrite && (w_off == REG_CTRL);
  assign w_abort     = w_ctrlWrite && cpu_wdata[CTRL_ABORT];
  assign w_start     = w_ctrlWrite && cpu_wdata[CTRL_START] && !w_abort;
  assign w_clearDone = w_ctrlWrite && cpu_wdata[CTRL_CLEAR_DONE];
  assign w_busy      = (r_state != ST_IDLE);
  assign w_empty     = (r_w == 7'd0) || (r_h == 7'd0);
  assign w_engWrite  = (r_state == ST_RUN) && !cpu_valid;
  assign w_load      = w_start && (r_state == ST_IDLE) && !w_empty;
  assign w_setDone   = !w_abort &&
                       ((w_start && (r_state == ST_IDLE) && w_empty) ||
                        (w_engWrite && w_last));

  tile_fill_walker u_walker (
    .clk    (clk),
    .resetn (resetn),
    .i_load (w_load),
    .i_step (w_engWrite),
    .i_x0   (r_x0),
    .i_y0   (r_y0),
    .i_w    (r_w),
    .i_h    (r_h),
    .o_cx   (w_cx),
    .o_cy   (w_cy),
    .o_last (w_last)
  );

`ifdef TILE_FILL_VBLANK_EN
  logic r_vsMeta;
  logic r_vsSync;
  logic r_vsPrev;
  logic r_vsFall;

  // Double-flop vsync into clk and register a one-cycle falling-edge pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vsMeta <= 1'b1;
      r_vsSync <= 1'b1;
      r_vsPrev <= 1'b1;
      r_vsFall <= 1'b0;
    end else begin
      r_vsMeta <= vga_vsync;
      r_vsSync <= r_vsMeta;
      r_vsPrev <= r_vsSync;
      r_vsFall <= r_vsPrev && !r_vsSync;
    end
  end
`else
  logic w_unusedVsync;
  assign w_unusedVsync = vga_vsync;
`endif

  // Fill FSM and done flag; abort overrides everything and leaves done alone,
  // and a done-setting event beats a simultaneous clear_done
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      if (w_abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start && !w_empty) begin
`ifdef TILE_FILL_VBLANK_EN
              r_state <= ST_WAIT_VS;
`else
              r_state <= ST_RUN;
`endif
            end
          end
          ST_WAIT_VS: begin
`ifdef TILE_FILL_VBLANK_EN
            if (r_vsFall) begin
              r_state <= ST_RUN;
            end
`else
            r_state <= ST_IDLE;
`endif
          end
          ST_RUN: begin
            if (w_engWrite && w_last) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
      if (w_setDone) begin
        r_done <= 1'b1;
      end else if (w_clearDone) begin
        r_done <= 1'b0;
      end
    end
  end

  // RECT and TILE are frozen while a fill is in progress
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_x0   <= '0;
      r_y0   <= '0;
      r_w    <= '0;
      r_h    <= '0;
      r_tile <= '0;
    end else if (w_regWrite && !w_busy) begin
      if (w_off == REG_RECT) begin
        r_x0 <= cpu_wdata[5:0];
        r_y0 <= cpu_wdata[13:8];
        r_w  <= cpu_wdata[22:16];
        r_h  <= cpu_wdata[30:24];
      end else if (w_off == REG_TILE) begin
        r_tile <= cpu_wdata[5:0];
      end
    end
  end

  // Readback selection for engine registers
  always_comb begin
    w_readMux = '0;
    case (w_off)
      REG_RECT: w_readMux = {1'b0, r_h, 1'b0, r_w, 2'b00, r_y0, 2'b00, r_x0};
      REG_TILE: w_readMux = {26'd0, r_tile};
      REG_CTRL: begin
        w_readMux[STAT_BUSY] = w_busy;
        w_readMux[STAT_DONE] = r_done;
      end
      default:  w_readMux = '0;
    endcase
  end

  // One-cycle ready pulse per access, with read data presented alongside it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cpuReady <= 1'b0;
      r_cpuRdata <= '0;
    end else begin
      r_cpuReady <= cpu_valid && !r_cpuReady;
      if (cpu_valid && !r_cpuReady && w_regAddr) begin
        r_cpuRdata <= w_readMux;
      end else begin
        r_cpuRdata <= '0;
      end
    end
  end

  assign cpu_ready = r_cpuReady;
  assign cpu_rdata = r_cpuRdata;

  // Video bus mux: CPU pass-through first, then the engine, else all zero
  always_comb begin
    vid_valid = 1'b0;
    vid_wstrb = 4'b0000;
    vid_addr  = '0;
    vid_wdata = '0;
    if (cpu_valid && !w_regAddr) begin
      vid_valid = 1'b1;
      vid_wstrb = cpu_wstrb;
      vid_addr  = cpu_addr;
      vid_wdata = cpu_wdata;
    end else if (w_engWrite) begin
      vid_valid = 1'b1;
      vid_wstrb = 4'b0001;
      vid_addr  = TILE_BASE + {18'd0, w_cy, w_cx, 2'b00};
      vid_wdata = {26'd0, r_tile};
    end
  end

endmodule

// File: tb/tb_tile_fill_ctrl.sv
// Directed testbench for tile_fill_ctrl. Engine writes are logged by a
// monitor (vid_valid while cpu_valid is low) and compared with hand-computed
// address lists. Build with TILE_FILL_VBLANK_EN to run the vsync scenario.
module tb_tile_fill_ctrl;

  localparam logic [31:0] RECT_A = 32'h0040_0000;
  localparam logic [31:0] TILE_A = 32'h0040_0004;
  localparam logic [31:0] CTRL_A = 32'h0040_0008;

  logic        clk;
  logic        resetn;
  logic        cpu_valid;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        vid_valid;
  logic [3:0]  vid_wstrb;
  logic [31:0] vid_addr;
  logic [31:0] vid_wdata;
  logic        vga_vsync;

  int          testsRun;
  int          testsFailed;
  int          engCount;
  int          engStrbBad;
  logic [31:0] engAddrQ[$];
  logic [31:0] engDataQ[$];
  logic [31:0] rd;

  tile_fill_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_valid (cpu_valid),
    .cpu_wstrb (cpu_wstrb),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .vid_valid (vid_valid),
    .vid_wstrb (vid_wstrb),
    .vid_addr  (vid_addr),
    .vid_wdata (vid_wdata),
    .vga_vsync (vga_vsync)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every engine-originated write at the falling edge
  always @(negedge clk) begin
    if (vid_valid && !cpu_valid) begin
      engCount = engCount + 1;
      engAddrQ.push_back(vid_addr);
      engDataQ.push_back(vid_wdata);
      if (vid_wstrb != 4'b0001) engStrbBad = engStrbBad + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun = testsRun + 1;
    if (observed !== expected) begin
      testsFailed = testsFailed + 1;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One CPU access; call just after a rising edge, returns just after one
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [31:0] rdata);
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_wstrb = strb;
    cpu_valid = 1'b1;
    @(posedge clk); #1;
    rdata = cpu_rdata;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    cpu_wstrb = 4'b0000;
    cpu_addr  = '0;
    cpu_wdata = '0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clearLog();
    engCount = 0;
    engAddrQ.delete();
    engDataQ.delete();
  endtask

  task automatic checkAddrs(input string tag, input logic [31:0] exp[]);
    checkOutput({tag, " count"}, 32'(engCount), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < engAddrQ.size(); i++) begin
      checkOutput($sformatf("%s addr%0d", tag, i), engAddrQ[i], exp[i]);
    end
  endtask

  logic [31:0] basicExp[] = '{32'h0520_0308, 32'h0520_030C, 32'h0520_0310, 32'h0520_0314,
                              32'h0520_0408, 32'h0520_040C, 32'h0520_0410, 32'h0520_0414};
  logic [31:0] wrapExp[]  = '{32'h0520_3FF8, 32'h0520_3FFC, 32'h0520_3F00,
                              32'h0520_00F8, 32'h0520_00FC, 32'h0520_0000};

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    engCount    = 0;
    engStrbBad  = 0;
    resetn      = 1'b0;
    cpu_valid   = 1'b0;
    cpu_wstrb   = '0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    vga_vsync   = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state
    checkOutput("reset cpu_ready", 32'(cpu_ready), 32'd0);
    checkOutput("reset cpu_rdata", cpu_rdata, 32'd0);
    checkOutput("reset vid_valid", 32'(vid_valid), 32'd0);
    checkOutput("reset vid_addr", vid_addr, 32'd0);
    applyStimulus(CTRL_A, 32'd0, 4'b0000, rd);
    checkOutput("reset status", rd, 32'd0);
    checkOutput("ready low after pulse", 32'(cpu_ready), 32'd0);

`ifdef TILE_FILL_VBLANK_EN
    // Start waits for a vsync falling edge
    applyStimulus(RECT_A, 32'h0202_0000, 4'hF, rd);
    applyStimulus(TILE_A, 32'd9, 4'hF, rd);
    clearLog();
    applyStimulus(CTRL_A, 32'd1, 4'hF, rd);
    waitCycles(5);
    checkOutput("vs no writes", 32'(engCount), 32'd0);
    applyStimulus(CTRL_A, 32'd0, 4'b0000, rd);
    checkOutput("vs busy", rd, 32'd1);
    vga_vsync = 1'b0;
    waitCycles(4);
    checkOutput("vs before first", 32'(engCount), 32'd0);
    waitCycles(1);
    checkOutput("vs first write", 32'(engCount), 32'd1);
    waitCycles(6);
    checkOutput("vs total", 32'(engCount), 32'd4);
`else
    // Basic fill x0=2 y0=3 w=4 h=2, value 5
    applyStimulus(RECT_A, 32'h0204_0302, 4'hF, rd);
    applyStimulus(TILE_A, 32'd5, 4'hF, rd);
    applyStimulus(RECT_A, 32'd0, 4'b0000, rd);
    checkOutput("rect readback", rd, 32'h0204_0302);
    clearLog();
    applyStimulus(CTRL_A, 32'd1, 4'hF, rd);
    waitCycles(1);
    checkOutput("first write latency", 32'(engCount), 32'd1);
    waitCycles(7);
    checkOutput("basic run length", 32'(engCount), 32'd8);
    waitCycles(4);
    checkAddrs("basic", basicExp);
    checkOutput("basic data", engDataQ[7], 32'd5);
    checkOutput("basic strobe", 32'(engStrbBad), 32'd0);
    applyStimulus(CTRL_A, 32'd0, 4'b0000, rd);
    checkOutput("basic status", rd, 32'd2);

    // Wrap-around x0=62 y0=63 w=3 h=2
    applyStimulus(RECT_A, 32'h0203_3F3E, 4'hF, rd);
    clearLog();
    applyStimulus(CTRL_A, 32'd1, 4'hF, rd);
    waitCycles(10);
    checkAddrs("wrap", wrapExp);

    // Contention: CPU video write mid-fill
    applyStimulus(RECT_A, 32'h0204_0302, 4'hF, rd);
    clearLog();
    applyStimulus(CTRL_A, 32'd1, 4'hF, rd);
    waitCycles(3);
    cpu_addr  = 32'h0520_0000;
    cpu_wdata = 32'hDEAD_BEEF;
    cpu_wstrb = 4'hF;
    cpu_valid = 1'b1;
    @(negedge clk);
    checkOutput("cont vid_valid", 32'(vid_valid), 32'd1);
    checkOutput("cont vid_addr", vid_addr, 32'h0520_0000);
    checkOutput("cont vid_wdata", vid_wdata, 32'hDEAD_BEEF);
    checkOutput("cont vid_wstrb", 32'(vid_wstrb), 32'hF);
    checkOutput("cont stalled", 32'(engCount), 32'd3);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    cpu_wstrb = '0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    waitCycles(10);
    checkAddrs("cont", basicExp);

    // Zero-width start completes immediately with no writes
    applyStimulus(CTRL_A, 32'd4, 4'hF, rd);
    applyStimulus(CTRL_A, 32'd0, 4'b0000, rd);
    checkOutput("clear_done status", rd, 32'd0);
    applyStimulus(RECT_A, 32'h0200_0000, 4'hF, rd);
    clearLog();
    applyStimulus(CTRL_A, 32'd1, 4'hF, rd);
    applyStimulus(CTRL_A, 32'd0, 4'b0000, rd);
    checkOutput("w0 status", rd, 32'd2);
    waitCycles(3);
    checkOutput("w0 writes", 32'(engCount), 32'd0);

    // Start and RECT writes while busy are ignored
    applyStimulus(CTRL_A, 32'd4, 4'hF, rd);
    applyStimulus(RECT_A, 32'h0404_0000, 4'hF, rd);
    clearLog();
    applyStimulus(CTRL_A, 32'd1, 4'hF, rd);
    applyStimulus(RECT_A, 32'h0101_0000, 4'hF, rd);
    applyStimulus(RECT_A, 32'd0, 4'b0000, rd);
    checkOutput("busy rect kept", rd, 32'h0404_0000);
    applyStimulus(CTRL_A, 32'd1, 4'hF, rd);
    applyStimulus(CTRL_A, 32'd0, 4'b0000, rd);
    checkOutput("busy status", rd, 32'd1);
    waitCycles(30);
    checkOutput("busy total writes", 32'(engCount), 32'd16);
    applyStimulus(CTRL_A, 32'd0, 4'b0000, rd);
    checkOutput("busy final status", rd, 32'd2);

    // Abort after three of sixteen writes
    applyStimulus(CTRL_A, 32'd4, 4'hF, rd);
    clearLog();
    applyStimulus(CTRL_A, 32'd1, 4'hF, rd);
    waitCycles(3);
    applyStimulus(CTRL_A, 32'd2, 4'hF, rd);
    waitCycles(10);
    checkOutput("abort writes", 32'(engCount), 32'd3);
    applyStimulus(CTRL_A, 32'd0, 4'b0000, rd);
    checkOutput("abort status", rd, 32'd0);

    // Reset mid-fill after five writes
    clearLog();
    applyStimulus(CTRL_A, 32'd1, 4'hF, rd);
    waitCycles(4);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    checkOutput("rst vid_valid", 32'(vid_valid), 32'd0);
    waitCycles(5);
    checkOutput("rst writes", 32'(engCount), 32'd5);
    applyStimulus(CTRL_A, 32'd0, 4'b0000, rd);
    checkOutput("rst status", rd, 32'd0);
    applyStimulus(RECT_A, 32'd0, 4'b0000, rd);
    checkOutput("rst rect", rd, 32'd0);
    applyStimulus(TILE_A, 32'd0, 4'b0000, rd);
    checkOutput("rst tile", rd, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
